// File: rtl/dmem_ctrl_pkg.sv
// Shared packages for the data-memory controller.
//   lsu_wires_pkg : one-hot LSU operation type carried on the pipeline wires.
//   dmem_ctrl_pkg : controller FSM states, the default timeout constant and
//                   the store-data replication helper.
// The optional access timeout is enabled with the DMEM_TIMEOUT_EN macro.

package lsu_wires_pkg;

  // One-hot load/store operation selector from the decode stage.
  typedef enum logic [7:0] {
    LSU_SB  = 8'b0000_0001,
    LSU_SH  = 8'b0000_0010,
    LSU_SW  = 8'b0000_0100,
    LSU_LB  = 8'b0000_1000,
    LSU_LBU = 8'b0001_0000,
    LSU_LH  = 8'b0010_0000,
    LSU_LHU = 8'b0100_0000,
    LSU_LW  = 8'b1000_0000
  } lsu_op_type;

endpackage

package dmem_ctrl_pkg;
  import lsu_wires_pkg::*;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_PEND = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_type;

  localparam int unsigned DMEM_TIMEOUT_DEFAULT = 256;

  // Replicate the store operand across the word so every enabled byte lane
  // carries the right data regardless of the address offset.
  function automatic logic [31:0] store_replicate(input lsu_op_type op,
                                                  input logic [31:0] wdata);
    logic [31:0] res;
    res = wdata;
    case (op)
      LSU_SB:  res = {4{wdata[7:0]}};
      LSU_SH:  res = {2{wdata[15:0]}};
      default: res = wdata;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/dmem_align.sv
// Load result extraction: picks the byte/halfword addressed by the low
// address bits out of the memory word and sign- or zero-extends it.
// Store operations produce zero.

module dmem_align
  import lsu_wires_pkg::*;
(
  input  lsu_op_type  op,
  input  logic [1:0]  offset,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Lane selection and extension by operation type.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path can leave it unassigned and infer a latch.
    data     = '0;
    byte_sel = rdata[8*offset +: 8];
    half_sel = offset[1] ? rdata[31:16] : rdata[15:0];
    case (op)
      LSU_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      LSU_LBU: data = {24'b0, byte_sel};
      LSU_LH:  data = {{16{half_sel[15]}}, half_sel};
      LSU_LHU: data = {16'b0, half_sel};
      LSU_LW:  data = rdata;
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: accepts one load/store from execute, issues a
// single memory request, waits for completion and returns a one-cycle
// response pulse. Flush kills the response but never the bus transaction.
// Optional feature: define DMEM_TIMEOUT_EN to abort requests that see no
// mem_ready within TIMEOUT_CYCLES pending cycles (response with rsp_fault).

module dmem_ctrl
  import lsu_wires_pkg::*;
  import dmem_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = DMEM_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_store,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_strb,
  input  logic [31:0] req_wdata,
  input  lsu_op_type  req_op,
  input  logic        req_exc,
  input  logic        flush,
  output logic        mem_valid,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_data,
  output logic        rsp_fault,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("dmem_ctrl: TIMEOUT_CYCLES must be at least 1");
  end

  dmem_state_type state;
  lsu_op_type     op_q;
  logic [1:0]     offset_q;
  logic           store_q;
  logic           kill_q;      // flush seen while pending: drop the response
  logic           rsp_valid_q;
  logic [31:0]    load_data;

  dmem_align u_align (
    .op     (op_q),
    .offset (offset_q),
    .rdata  (mem_rdata),
    .data   (load_data)
  );

  logic accept;
  assign accept = req_valid && !req_exc && !flush && (req_strb != 4'b0);

  assign busy      = (state != DMEM_IDLE);
  assign rsp_valid = rsp_valid_q && !flush;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] tmo_cnt;
  logic             fault_q;
  assign rsp_fault = fault_q;
`else
  assign rsp_fault = 1'b0;
`endif

  // Controller FSM with registered memory request and response fields.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: all state, including datapath registers, is cleared by the async
    // reset so no stale request is visible on the bus after reset; state is
    // updated with non-blocking assignments only.
    if (!rst_n) begin
      state       <= DMEM_IDLE;
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data    <= '0;
      op_q        <= LSU_LW;
      offset_q    <= '0;
      store_q     <= 1'b0;
      kill_q      <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
      tmo_cnt     <= '0;
      fault_q     <= 1'b0;
`endif
    end else begin
      case (state)
        DMEM_IDLE: begin
          if (accept) begin
            mem_valid <= 1'b1;
            mem_addr  <= {req_addr[31:2], 2'b00};
            mem_wstrb <= req_store ? req_strb : 4'b0;
            mem_wdata <= req_store ? store_replicate(req_op, req_wdata) : '0;
            op_q      <= req_op;
            offset_q  <= req_addr[1:0];
            store_q   <= req_store;
            kill_q    <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
            tmo_cnt   <= '0;
`endif
            state     <= DMEM_PEND;
          end
        end
        DMEM_PEND: begin
          if (flush) kill_q <= 1'b1;
          if (mem_ready) begin
            mem_valid   <= 1'b0;
            rsp_data    <= store_q ? 32'b0 : load_data;
            rsp_valid_q <= !(kill_q || flush);
            state       <= DMEM_RESP;
          end
`ifdef DMEM_TIMEOUT_EN
          else if (tmo_cnt == CNT_LAST) begin
            mem_valid   <= 1'b0;
            rsp_data    <= '0;
            fault_q     <= 1'b1;
            rsp_valid_q <= !(kill_q || flush);
            state       <= DMEM_RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
`endif
        end
        DMEM_RESP: begin
          rsp_valid_q <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
          fault_q     <= 1'b0;
`endif
          state       <= DMEM_IDLE;
        end
        default: state <= DMEM_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed testbench for dmem_ctrl. Inputs are driven and outputs sampled
// 1 ns after the rising edge. With DMEM_TIMEOUT_EN defined the DUT is built
// with TIMEOUT_CYCLES=4 and the timeout path is exercised as well.

module tb_dmem_ctrl;
  import lsu_wires_pkg::*;

`ifdef DMEM_TIMEOUT_EN
  localparam int unsigned TB_TMO = 4;
`else
  localparam int unsigned TB_TMO = 256;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_strb = '0;
  logic [31:0] req_wdata = '0;
  lsu_op_type  req_op = LSU_LW;
  logic        req_exc = 1'b0;
  logic        flush = 1'b0;
  logic        mem_valid;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_fault;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dmem_ctrl #(.TIMEOUT_CYCLES(TB_TMO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_store (req_store),
    .req_addr  (req_addr),
    .req_strb  (req_strb),
    .req_wdata (req_wdata),
    .req_op    (req_op),
    .req_exc   (req_exc),
    .flush     (flush),
    .mem_valid (mem_valid),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_fault (rsp_fault),
    .busy      (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present one request, complete it after 'wait_cycles' not-ready cycles
  // and check the bus request and the response against expected values.
  task automatic access(input string tag, input logic st, input lsu_op_type op,
                        input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] wdata, input logic [31:0] rdata,
                        input int wait_cycles, input logic [31:0] exp_addr,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_wstrb,
                        input logic [31:0] exp_rsp);
    req_valid = 1'b1; req_store = st; req_op = op;
    req_addr = addr; req_strb = strb; req_wdata = wdata;
    step();
    req_valid = 1'b0;
    check({tag, " mem_valid"}, {31'b0, mem_valid}, 32'd1);
    check({tag, " mem_addr"},  mem_addr, exp_addr);
    check({tag, " mem_wdata"}, mem_wdata, exp_wdata);
    check({tag, " mem_wstrb"}, {28'b0, mem_wstrb}, {28'b0, exp_wstrb});
    check({tag, " busy pend"}, {31'b0, busy}, 32'd1);
    for (int i = 0; i < wait_cycles; i++) begin
      step();
      check({tag, " mem_valid hold"}, {31'b0, mem_valid}, 32'd1);
    end
    mem_ready = 1'b1; mem_rdata = rdata;
    step();
    mem_ready = 1'b0; mem_rdata = 32'h5555_5555;
    check({tag, " rsp_valid"}, {31'b0, rsp_valid}, 32'd1);
    check({tag, " rsp_data"},  rsp_data, exp_rsp);
    check({tag, " rsp_fault"}, {31'b0, rsp_fault}, 32'd0);
    check({tag, " mem_valid done"}, {31'b0, mem_valid}, 32'd0);
    step();
    check({tag, " rsp_valid pulse"}, {31'b0, rsp_valid}, 32'd0);
    check({tag, " busy idle"}, {31'b0, busy}, 32'd0);
  endtask

  initial begin
    // Reset state
    #12;
    check("reset mem_valid", {31'b0, mem_valid}, 32'd0);
    check("reset mem_addr",  mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset mem_wstrb", {28'b0, mem_wstrb}, 32'd0);
    check("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("reset rsp_data",  rsp_data, 32'd0);
    check("reset busy",      {31'b0, busy}, 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Loads and stores, minimum latency
    access("lw",  1'b0, LSU_LW,  32'h100, 4'hF, 32'h0, 32'hDEADBEEF, 0,
           32'h100, 32'h0, 4'h0, 32'hDEADBEEF);
    access("lb",  1'b0, LSU_LB,  32'h103, 4'h8, 32'h0, 32'h80FFFFFF, 0,
           32'h100, 32'h0, 4'h0, 32'hFFFFFF80);
    access("lbu", 1'b0, LSU_LBU, 32'h103, 4'h8, 32'h0, 32'h80FFFFFF, 0,
           32'h100, 32'h0, 4'h0, 32'h00000080);
    access("lhu", 1'b0, LSU_LHU, 32'h102, 4'hC, 32'h0, 32'h80015A5A, 1,
           32'h100, 32'h0, 4'h0, 32'h00008001);
    access("lh",  1'b0, LSU_LH,  32'h102, 4'hC, 32'h0, 32'h80015A5A, 0,
           32'h100, 32'h0, 4'h0, 32'hFFFF8001);
    access("lb1", 1'b0, LSU_LB,  32'h301, 4'h2, 32'h0, 32'h11223344, 0,
           32'h300, 32'h0, 4'h0, 32'h00000033);
    access("sh",  1'b1, LSU_SH,  32'h206, 4'hC, 32'h1234ABCD, 32'hFFFFFFFF, 0,
           32'h204, 32'hABCDABCD, 4'hC, 32'h0);
    access("sb",  1'b1, LSU_SB,  32'h101, 4'h2, 32'h000000A5, 32'hFFFFFFFF, 2,
           32'h100, 32'hA5A5A5A5, 4'h2, 32'h0);
    access("sw",  1'b1, LSU_SW,  32'h40C, 4'hF, 32'hCAFEF00D, 32'hFFFFFFFF, 0,
           32'h40C, 32'hCAFEF00D, 4'hF, 32'h0);

    // Flush in PEND: transaction completes, response suppressed
    req_valid = 1'b1; req_store = 1'b0; req_op = LSU_LW; req_addr = 32'h500; req_strb = 4'hF;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      flush = (i == 1);
      check("flush pend mem_valid", {31'b0, mem_valid}, 32'd1);
      step();
    end
    flush = 1'b0;
    check("flush pend mem_valid last", {31'b0, mem_valid}, 32'd1);
    mem_ready = 1'b1; mem_rdata = 32'h12345678;
    step();
    mem_ready = 1'b0;
    check("flush pend rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("flush pend busy resp", {31'b0, busy}, 32'd1);
    step();
    check("flush pend busy idle", {31'b0, busy}, 32'd0);
    check("flush pend rsp_valid idle", {31'b0, rsp_valid}, 32'd0);

    // Flush in RESP suppresses the pulse
    req_valid = 1'b1; req_addr = 32'h600;
    step();
    req_valid = 1'b0; mem_ready = 1'b1;
    step();
    mem_ready = 1'b0; flush = 1'b1;
    #1;
    check("flush resp rsp_valid", {31'b0, rsp_valid}, 32'd0);
    step();
    flush = 1'b0;
    check("flush resp busy", {31'b0, busy}, 32'd0);

    // Rejected requests: exception, zero strobes, flush
    req_valid = 1'b1; req_exc = 1'b1; req_addr = 32'h700;
    step();
    check("exc mem_valid", {31'b0, mem_valid}, 32'd0);
    check("exc busy", {31'b0, busy}, 32'd0);
    req_exc = 1'b0; req_strb = 4'h0;
    step();
    check("strb0 mem_valid", {31'b0, mem_valid}, 32'd0);
    req_strb = 4'hF; flush = 1'b1;
    step();
    check("flush idle mem_valid", {31'b0, mem_valid}, 32'd0);
    flush = 1'b0; req_valid = 1'b0;
    step();

    // Reset mid-PEND abandons the transaction
    req_valid = 1'b1; req_addr = 32'h800;
    step();
    req_valid = 1'b0;
    check("rst pend mem_valid before", {31'b0, mem_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst pend mem_valid", {31'b0, mem_valid}, 32'd0);
    check("rst pend busy", {31'b0, busy}, 32'd0);
    check("rst pend mem_addr", mem_addr, 32'd0);
    step();
    rst_n = 1'b1;
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("rst pend no rsp", {31'b0, rsp_valid}, 32'd0);
      check("rst pend idle", {31'b0, busy}, 32'd0);
    end
    mem_ready = 1'b0;

`ifdef DMEM_TIMEOUT_EN
    // Timeout: mem_ready never arrives
    req_valid = 1'b1; req_addr = 32'h900;
    step();
    req_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check("tmo mem_valid", {31'b0, mem_valid}, 32'd1);
      step();
    end
    check("tmo mem_valid drop", {31'b0, mem_valid}, 32'd0);
    check("tmo rsp_valid", {31'b0, rsp_valid}, 32'd1);
    check("tmo rsp_fault", {31'b0, rsp_fault}, 32'd1);
    check("tmo rsp_data", rsp_data, 32'd0);
    step();
    mem_ready = 1'b1;
    check("tmo busy idle", {31'b0, busy}, 32'd0);
    check("tmo fault clear", {31'b0, rsp_fault}, 32'd0);
    step();
    mem_ready = 1'b0;
    check("tmo late ready ignored", {31'b0, rsp_valid}, 32'd0);
    check("tmo late ready busy", {31'b0, busy}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 256: PEND cycles before abort; used only with DMEM_TIMEOUT_EN.
REQ-002 reset  in  1  asynchronous, active-low.
REQ-003 clock  in  1  rising-edge clock.
REQ-004 req_valid  in  1  load or store presented by execute stage.
REQ-005 req_store  in  1  1 = store, 0 = load.
REQ-006 req_addr  in  32  byte address from address generation.
REQ-007 req_strb  in  4  byte enables from address generation.
REQ-008 req_wdata  in  32  raw rs2 store data.
REQ-009 req_op  in  lsu_op_type  sb/sh/sw/lb/lbu/lh/lhu/lw one-hot.
REQ-010 req_exc  in  1  address-generation exception; suppresses request.
REQ-011 flush  in  1  pipeline kill.
REQ-012 mem_valid/mem_addr/mem_wdata/mem_wstrb  out  1/32/32/4  memory request.
REQ-013 mem_ready/mem_rdata  in  1/32  memory completion, read data.
REQ-014 rsp_valid/rsp_data/rsp_fault  out  1/32/1  response pulse, load result, timeout fault.
REQ-015 busy  out  1  upstream stall.

Function
REQ-016 FSM states IDLE, PEND, RESP; busy SHALL be 1 in PEND and RESP.
REQ-017 Accept in IDLE iff req_valid=1, req_exc=0, flush=0, req_strb!=0; else stay IDLE.
REQ-018 On accept, register mem_addr={req_addr[31:2],2'b00}, mem_wstrb=req_strb if store else 0, enter PEND with mem_valid=1.
REQ-019 Store data SHALL be replicated: sb {4{wdata[7:0]}}, sh {2{wdata[15:0]}}, sw wdata.
REQ-020 mem_valid and request fields SHALL hold stable in PEND until mem_valid&mem_ready.
REQ-021 On completion, capture mem_rdata, enter RESP; rsp_valid=1 for exactly one cycle in RESP; RESP->IDLE unconditionally.
REQ-022 Load result: select byte/half by req_addr[1:0]; lb/lh sign-extend, lbu/lhu zero-extend, lw pass-through; stores return rsp_data=0.
REQ-023 Minimum latency: accept at t, mem_valid at t+1, mem_ready at t+1 gives rsp_valid at t+2; max throughput one access per 3 cycles.
REQ-024 flush in PEND SHALL NOT drop mem_valid; transaction completes, RESP entered with rsp_valid suppressed.
REQ-025 flush in RESP SHALL suppress rsp_valid that cycle.
REQ-026 req_valid while busy=1 SHALL be ignored; upstream holds it.

Reset
REQ-027 reset=0 SHALL immediately force IDLE, mem_valid=0, mem_addr/mem_wdata/mem_wstrb=0, rsp_valid=0, rsp_data=0, rsp_fault=0, busy=0, timeout counter=0.
REQ-028 reset mid-PEND SHALL abandon the transaction; no response produced after release.

Configuration
REQ-029 With DMEM_TIMEOUT_EN defined, a counter SHALL increment each PEND cycle without mem_ready; at TIMEOUT_CYCLES, mem_valid drops, RESP entered with rsp_fault=1, rsp_data=0.
REQ-030 Under DMEM_TIMEOUT_EN, mem_ready arriving after abort in IDLE SHALL be ignored; counter clears on PEND entry.
REQ-031 Without DMEM_TIMEOUT_EN, no counter exists, PEND waits indefinitely, rsp_fault tied 0.

Structure
REQ-032 dmem_state_type enum and default timeout constant SHALL live in the shared constants package; lsu_op_type stays in the shared wires package.
REQ-033 Load extraction/extension SHALL be one combinational sub-module dmem_align.

Verification
REQ-034 lw addr 0x100, strb F, mem_ready at t+1, rdata 0xDEADBEEF -> mem_addr 0x100, rsp_valid at t+2, rsp_data 0xDEADBEEF.
REQ-035 lb addr 0x103, rdata 0x80FFFFFF -> rsp_data 0xFFFFFF80; lbu same -> 0x00000080; lhu addr 0x102, rdata 0x8001xxxx -> 0x00008001.
REQ-036 sh addr 0x206, wdata 0x1234ABCD -> mem_wdata 0xABCDABCD, mem_wstrb 0xC, rsp_data 0.
REQ-037 mem_ready held low 5 cycles, flush at 2nd PEND cycle -> mem_valid stays 1 until ready, no rsp_valid, busy falls after RESP.
REQ-038 req_exc=1 with req_valid=1 -> no mem_valid, busy 0; reset asserted mid-PEND -> mem_valid 0 same cycle, no response.
REQ-039 DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready never -> mem_valid drops after 4 PEND cycles, rsp_valid=1, rsp_fault=1.
